// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch stage: assembles big-endian words into a prefetch queue.
// Define IFU_PERF_EN to add the perf_words / perf_flushes saturating counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [7:0]  mem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_words,
    output logic [15:0] perf_flushes
`endif
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [31:0]     word_q, word_d;
    logic            misalign_q;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     q_pc_q    [QDEPTH];
    logic [31:0]     q_instr_q [QDEPTH];
    logic            push_s, pop_s, if_valid_s, outstanding_s;
    logic [CW-1:0]   count_after_push_s;

    // Byte 0 of a word lands in bits 31:24 (big-endian assembly).
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  data);
        logic [31:0] res;
        res = word;
        case (idx)
            2'd0:    res[31:24] = data;
            2'd1:    res[23:16] = data;
            2'd2:    res[15:8]  = data;
            2'd3:    res[7:0]   = data;
            default: res        = word;
        endcase
        return res;
    endfunction

    assign if_valid_s    = (count_q != {CW{1'b0}});
    assign pop_s         = if_valid_s && if_ready && !redirect_valid;
    assign outstanding_s = ((state_q == ST_REQ) && mem_gnt) ||
                           (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && !mem_rvalid);
    assign count_after_push_s = count_q + {{(CW-1){1'b0}}, 1'b1} - {{(CW-1){1'b0}}, pop_s};

    // Next-state logic for the fetch sequencer; a redirect overrides every other event.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        push_s     = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            byte_idx_d = 2'd0;
            word_d     = 32'd0;
            if (outstanding_s) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q < QFULL) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        word_d = insert_byte(word_q, byte_idx_q, mem_rdata);
                        if (byte_idx_q != 2'd3) begin
                            byte_idx_d = byte_idx_q + 2'd1;
                            state_d    = ST_REQ;
                        end else begin
                            push_s     = 1'b1;
                            fetch_pc_d = fetch_pc_q + 32'd4;
                            byte_idx_d = 2'd0;
                            if (count_after_push_s < QFULL) begin
                                state_d = ST_REQ;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (mem_rvalid) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Queue occupancy after this cycle's push/pop; a redirect empties it.
    always_comb begin
        if (redirect_valid) begin
            count_d = {CW{1'b0}};
        end else begin
            count_d = count_q + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
        end
    end

    // Sequencer registers and the one-cycle misalign flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            byte_idx_q <= 2'd0;
            word_q     <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    // Prefetch queue storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= {PW{1'b0}};
            wr_ptr_q  <= {PW{1'b0}};
            count_q   <= {CW{1'b0}};
            q_pc_q    <= '{default: 32'd0};
            q_instr_q <= '{default: 32'd0};
        end else if (redirect_valid) begin
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
            if (push_s) begin
                q_pc_q[wr_ptr_q]    <= fetch_pc_q;
                q_instr_q[wr_ptr_q] <= word_d;
                wr_ptr_q            <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    assign mem_req  = (state_q == ST_REQ);
    assign mem_addr = fetch_pc_q + {30'd0, byte_idx_q};
    assign if_valid = if_valid_s;
    assign if_instr = if_valid_s ? q_instr_q[rd_ptr_q] : 32'd0;
    assign if_pc    = if_valid_s ? q_pc_q[rd_ptr_q]    : 32'd0;
    assign misalign = misalign_q;

`ifdef IFU_PERF_EN
    logic [31:0] perf_words_q;
    logic [15:0] perf_flushes_q;

    // Saturating counters of pushed words and accepted redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_words_q   <= 32'd0;
            perf_flushes_q <= 16'd0;
        end else begin
            if (push_s && (perf_words_q != {32{1'b1}})) begin
                perf_words_q <= perf_words_q + 32'd1;
            end
            if (redirect_valid && (perf_flushes_q != {16{1'b1}})) begin
                perf_flushes_q <= perf_flushes_q + 16'd1;
            end
        end
    end

    assign perf_words   = perf_words_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule
